// File: rtl/spi_pkg.sv
// Shared types for the full-duplex SPI master: FSM states, per-command mode and
// the parity that marks leading versus trailing sclk edges.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // Edge index e within SHIFT: even e is the leading edge, odd e the trailing edge.
  localparam logic EDGE_LEAD  = 1'b0;
  localparam logic EDGE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: counts clk cycles and pulses tick on the last cycle of each
// CLK_DIV-cycle period, wrapping so consecutive periods follow without a gap.
module spi_clk_tick #(
  parameter int CLK_DIV = 11
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: one command at a time, per-command CPOL/CPHA/bit order,
// shifts DATA_W bits out on mosi while capturing DATA_W bits from miso.
module spi_master_duplex
  import spi_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 11,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic              cmd_lsb_first,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [1:0]        dbg_state
);

  // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and out of reset. rsp_valid is a one-cycle
  // pulse with no backpressure; rsp_data holds until the next completion.

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [EW-1:0]     edge_cnt;
  logic [EW-1:0]     next_e;
  logic              tick;
  logic              do_edge;
  logic              do_sample;
  logic              do_drive;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                  input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                 input logic b, input logic lsb);
    return lsb ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices select nothing, so all chip selects stay high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++) r[i] = (int'(idx) != i);
    return r;
  endfunction

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .clear  (rst || (state == IDLE)),
    .enable (1'b1),
    .tick   (tick)
  );

  // The SETUP expiry produces edge 0; each later SHIFT expiry produces the next
  // edge, except the one after the final edge, which moves to GAP instead.
  assign next_e    = (state == SETUP) ? '0 : edge_cnt + 1'b1;
  assign do_edge   = tick && ((state == SETUP) ||
                              ((state == SHIFT) && (edge_cnt != LAST_EDGE)));
  assign do_sample = do_edge && (next_e[0] == (mode.cpha ? EDGE_TRAIL : EDGE_LEAD));
  assign do_drive  = do_edge && (mode.cpha ? (next_e[0] == EDGE_LEAD)
                                           : ((next_e[0] == EDGE_TRAIL) &&
                                              (next_e != LAST_EDGE)));

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      edge_cnt  <= '0;
      sclk      <= 1'b0;
      cs_n      <= '1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode     <= '{cpol: cmd_cpol, cpha: cmd_cpha, lsb_first: cmd_lsb_first};
            sclk     <= cmd_cpol;
            cs_n     <= cs_decode(cmd_cs);
            rx_sh    <= '0;
            edge_cnt <= '0;
            // CPHA=0 slaves sample on the first edge, so bit 0 must already be out.
            if (!cmd_cpha) begin
              mosi  <= first_bit(cmd_data, cmd_lsb_first);
              tx_sh <= shift_out(cmd_data, cmd_lsb_first);
            end else begin
              tx_sh <= cmd_data;
            end
            state <= SETUP;
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: begin
          if (tick && (edge_cnt == LAST_EDGE)) begin
            state     <= GAP;
            cs_n      <= '1;
            mosi      <= 1'b0;
            sclk      <= mode.cpol;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sh;
          end
        end
        GAP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (do_edge) begin
        sclk     <= ~sclk;
        edge_cnt <= next_e;
      end
      if (do_sample) rx_sh <= shift_in(rx_sh, miso, mode.lsb_first);
      if (do_drive) begin
        mosi  <= first_bit(tx_sh, mode.lsb_first);
        tx_sh <= shift_out(tx_sh, mode.lsb_first);
      end
    end
  end

endmodule
